// File: rtl/branch_ckpt_ctrl.sv
// Branch checkpoint slot allocator: grants map-table snapshot slots, frees them on resolve/retire,
// and drives restore/squash on mispredict. Optional perf counters under BRANCH_CKPT_PERF_EN.
module branch_ckpt_ctrl #(
    parameter int NUM_CKPT = 4,
    parameter int ROB_SZ   = 32,
    parameter int TAG_W    = 5,
    localparam int IDX_W   = $clog2(NUM_CKPT),
    localparam int CNT_W   = IDX_W + 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                alloc_req,
    input  logic [TAG_W-1:0]    alloc_rob_tag,
    output logic                alloc_gnt,
    output logic [IDX_W-1:0]    alloc_idx,
    output logic                stall,
    input  logic                resolve_valid,
    input  logic [TAG_W-1:0]    resolve_rob_tag,
    input  logic                resolve_mispredict,
    input  logic                retire_valid,
    input  logic [TAG_W-1:0]    retire_rob_tag,
    input  logic [TAG_W-1:0]    rob_head,
    output logic                restore_valid,
    output logic [IDX_W-1:0]    restore_idx,
    output logic [NUM_CKPT-1:0] squash_mask,
    output logic [NUM_CKPT-1:0] busy_mask,
    output logic [CNT_W-1:0]    free_count
`ifdef BRANCH_CKPT_PERF_EN
    ,
    output logic [31:0]         perf_full_stall_cycles,
    output logic [31:0]         perf_mispredicts
`endif
);

    typedef enum logic {IDLE, RECOVER} state_t;

    state_t              state;
    logic [NUM_CKPT-1:0] busy;
    logic [NUM_CKPT-1:0] squash_q;
    logic [IDX_W-1:0]    restore_q;
    logic                restore_vld_q;
    logic [TAG_W-1:0]    tags [NUM_CKPT];

    logic [NUM_CKPT-1:0] res_hit;
    logic [NUM_CKPT-1:0] ret_hit;
    logic [NUM_CKPT-1:0] squash_next;
    logic [NUM_CKPT-1:0] clear;
    logic [NUM_CKPT-1:0] alloc_vec;
    logic                res_any;
    logic [IDX_W-1:0]    mis_idx;
    logic [IDX_W-1:0]    free_idx;
    logic [CNT_W-1:0]    free_cnt;
    logic [TAG_W-1:0]    mis_age;
    logic [TAG_W-1:0]    slot_age;
    logic                mispredict_now;

    // Downward scan so the last assignment wins, giving lowest-index priority.
    always_comb begin
        res_hit  = '0;
        ret_hit  = '0;
        res_any  = 1'b0;
        mis_idx  = '0;
        free_idx = '0;
        free_cnt = '0;
        for (int i = NUM_CKPT - 1; i >= 0; i--) begin
            res_hit[i] = busy[i] && (tags[i] == resolve_rob_tag);
            ret_hit[i] = busy[i] && retire_valid && (tags[i] == retire_rob_tag);
            if (res_hit[i]) begin
                res_any = 1'b1;
                mis_idx = IDX_W'(i);
            end
            if (!busy[i]) begin
                free_idx = IDX_W'(i);
            end
            free_cnt = free_cnt + CNT_W'(!busy[i]);
        end
    end

    assign mispredict_now = (state == IDLE) && resolve_valid && resolve_mispredict && res_any;
    assign mis_age        = tags[mis_idx] - rob_head;

    // Ages are offsets from the ROB head; TAG_W-bit subtraction handles the wrap.
    always_comb begin
        squash_next = '0;
        slot_age    = '0;
        for (int i = 0; i < NUM_CKPT; i++) begin
            slot_age       = tags[i] - rob_head;
            squash_next[i] = busy[i] && ((IDX_W'(i) == mis_idx) || (slot_age > mis_age));
        end
    end

    assign alloc_gnt = (state == IDLE) && alloc_req && (free_cnt != '0) && !mispredict_now;
    assign alloc_idx = free_idx;
    assign stall     = (alloc_req && !alloc_gnt) || (state == RECOVER);

    always_comb begin
        clear     = '0;
        alloc_vec = '0;
        if (state == RECOVER) begin
            clear = squash_q | ret_hit;
        end else if (mispredict_now) begin
            // Only older slots may free now; younger ones leave with the squash.
            clear = ret_hit & ~squash_next;
        end else begin
            clear = ret_hit | ((resolve_valid && !resolve_mispredict) ? res_hit : '0);
        end
        if (alloc_gnt) begin
            alloc_vec[free_idx] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            busy          <= '0;
            squash_q      <= '0;
            restore_q     <= '0;
            restore_vld_q <= 1'b0;
            for (int i = 0; i < NUM_CKPT; i++) begin
                tags[i] <= '0;
            end
        end else begin
            busy <= (busy & ~clear) | alloc_vec;
            if (alloc_gnt) begin
                tags[free_idx] <= alloc_rob_tag;
            end
            case (state)
                IDLE: begin
                    if (mispredict_now) begin
                        state         <= RECOVER;
                        squash_q      <= squash_next;
                        restore_q     <= mis_idx;
                        restore_vld_q <= 1'b1;
                    end
                end
                RECOVER: begin
                    state         <= IDLE;
                    squash_q      <= '0;
                    restore_q     <= '0;
                    restore_vld_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign restore_valid = restore_vld_q;
    assign restore_idx   = restore_q;
    assign squash_mask   = squash_q;
    assign busy_mask     = busy;
    assign free_count    = free_cnt;

`ifdef BRANCH_CKPT_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_full_stall_cycles <= '0;
            perf_mispredicts       <= '0;
        end else begin
            if (alloc_req && (free_cnt == '0) && (perf_full_stall_cycles != '1)) begin
                perf_full_stall_cycles <= perf_full_stall_cycles + 32'd1;
            end
            if (mispredict_now && (perf_mispredicts != '1)) begin
                perf_mispredicts <= perf_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule
